mem_arb: RTL and testbench
==========================

# mem_arb

Memory-port arbiter and access sequencer for the single-port data/program RAM. Shares the RAM between two requesters, the control unit (CPU port, index 0) and the program loader/DMA engine (DMA port, index 1), using round-robin arbitration. It sequences each access through address, read-wait and response phases. It owns the RAM address, write-data and write-enable pins, so no other block drives the RAM directly.

## Interface

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- RAM_LAT, 1, RAM read latency in cycles from the address cycle to valid ram_rdata; legal range 1..4

Ports:
- arb_clk  in  1  the block's only clock; all state changes on its rising edge
- arb_rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request; held high until cpu_done is sampled high
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: the CPU access has started
- cpu_done  out  1  one-cycle pulse: the CPU access is complete; cpu_rdata is valid in the same cycle
- cpu_rdata  out  DATA_W  read data, held until the next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata  same directions, widths and rules as the CPU port
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  high in every state except IDLE

## Operation

- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_gnt.
  - On a grant: latch the winner's we, addr and wdata into internal registers, update last_gnt, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (1 cycle):
  - The granted port's gnt is high.
  - ram_addr and ram_wdata come from the latched values; ram_we = latched we.
  - Write: go to RESP. Read: load wait_cnt = RAM_LAT-1, go to WAIT.
- WAIT:
  - ram_addr is held; ram_we = 0.
  - If wait_cnt == 0: capture ram_rdata into the granted port's rdata register and go to RESP. Otherwise decrement wait_cnt.
- RESP (1 cycle): the granted port's done is high, then go to IDLE. Arbitration happens only in IDLE.
- The non-granted port's rdata register is never modified.
- A requester drops req on the edge at which it samples done high. A req that is still high in IDLE is treated as a new request.
- last_gnt resets to DMA, so the CPU wins the first tie.
- Changing we, addr or wdata while req is high and before gnt is allowed; the values sampled on the granting edge are used.
- Dropping req after gnt does not abort the access. done still pulses.

## Timing

- Write: req sampled at edge 0; gnt and ram_we high in cycle 1; done in cycle 2; back in IDLE in cycle 3.
- Read: gnt in cycle 1; done and rdata valid in cycle 2+RAM_LAT. RAM_LAT = 1 gives done in cycle 3.
- Both ports continuously requesting: the grants alternate, with one access every 3 cycles (write) or 3+RAM_LAT cycles (read).
- Reset values: state IDLE; gnt, done, ram_we and busy all 0; ram_addr, ram_wdata and both rdata registers 0; last_gnt DMA; wait_cnt 0.
- Reset mid-access: everything returns to the reset values asynchronously and ram_we drops immediately. The in-flight access is abandoned with no done pulse, and a write cut off in ACCESS is undefined at the RAM. Requesters must reissue after reset.
- Outputs are registered or decoded from state only; no combinational path from req to ram_*.

## Structure

- Shared package mem_pkg: state encodings (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3) and port indices (PORT_CPU=1'b0, PORT_DMA=1'b1).
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: valid, idx.
  - Reusable for any future second shared resource.
- Everything else, including the FSM, the latches and wait_cnt, lives in mem_arb.

## Test plan

- Reset: hold arb_rst, then release with no requests → all outputs 0, busy 0; RAM model untouched for 10 cycles.
- CPU write addr 0x3C data 0xA5, then CPU read 0x3C, RAM_LAT=1 → write: cpu_gnt in cycle 1, ram_we high in cycle 1 only, cpu_done in cycle 2. Read: cpu_done in cycle 3 with cpu_rdata=0xA5; dma_rdata stays 0.
- Both ports raise req on the same edge and hold: CPU reads 0x10, DMA writes 0x20=0x5A → CPU is granted first, then DMA; across 4 transactions the grant order is C,D,C,D, and no dma_gnt appears during a CPU access.
- RAM_LAT=3 build, DMA read 0xFF=0x77 → dma_done exactly 5 cycles after the request edge; ram_we stays 0 throughout; dma_rdata=0x77.
- Assert arb_rst during the WAIT state of a CPU read → no cpu_done; state IDLE and busy 0 immediately. A request reissued after reset completes normally.
- Drop cpu_req in the cycle after cpu_gnt → the access still completes with a cpu_done pulse, and no second access starts.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the RAM port arbiter.
// State encodings and requester indices.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// On a tie the port that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;
  assign idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arb.sv
// RAM port arbiter: CPU vs DMA, round-robin.
// Sequences each access through ACCESS, WAIT and RESP.
module mem_arb
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 1);

  arb_state_e state;
  logic       last_gnt;
  logic       lat_we;
  logic [1:0] wait_cnt;
  logic       pick_v;
  logic       pick_idx;

  rr_pick2 u_pick (
    .req   ({dma_req, cpu_req}),
    .last  (last_gnt),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  assign busy = (state != IDLE);

  // ram_addr/ram_wdata double as the latched request fields
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state     <= IDLE;
      last_gnt  <= PORT_DMA;
      lat_we    <= 1'b0;
      wait_cnt  <= '0;
      cpu_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else begin
      cpu_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      ram_we   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_v) begin
            last_gnt <= pick_idx;
            if (pick_idx == PORT_DMA) begin
              lat_we    <= dma_we;
              ram_we    <= dma_we;
              ram_addr  <= dma_addr;
              ram_wdata <= dma_wdata;
              dma_gnt   <= 1'b1;
            end else begin
              lat_we    <= cpu_we;
              ram_we    <= cpu_we;
              ram_addr  <= cpu_addr;
              ram_wdata <= cpu_wdata;
              cpu_gnt   <= 1'b1;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            cpu_done <= (last_gnt == PORT_CPU);
            dma_done <= (last_gnt == PORT_DMA);
            state    <= RESP;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (last_gnt == PORT_DMA) begin
              dma_rdata <= ram_rdata;
              dma_done  <= 1'b1;
            end else begin
              cpu_rdata <= ram_rdata;
              cpu_done  <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb with a latency-accurate RAM model.
// Randomized and directed CPU/DMA traffic against a reference model.
module tb_mem_arb;

  localparam int LAT = 3;

  bit         arb_clk;
  logic       arb_rst;
  logic [1:0] req, we;
  logic [7:0] addr [2];
  logic [7:0] wdata[2];
  logic [1:0] gnt, done;
  logic [7:0] rdata[2];
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, busy;

  mem_arb #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(LAT)) u_dut (
    .arb_clk   (arb_clk),
    .arb_rst   (arb_rst),
    .cpu_req   (req[0]),
    .cpu_we    (we[0]),
    .cpu_addr  (addr[0]),
    .cpu_wdata (wdata[0]),
    .cpu_gnt   (gnt[0]),
    .cpu_done  (done[0]),
    .cpu_rdata (rdata[0]),
    .dma_req   (req[1]),
    .dma_we    (we[1]),
    .dma_addr  (addr[1]),
    .dma_wdata (wdata[1]),
    .dma_gnt   (gnt[1]),
    .dma_done  (done[1]),
    .dma_rdata (rdata[1]),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 arb_clk = ~arb_clk;

  int cyc;
  always @(posedge arb_clk) cyc <= cyc + 1;

  function automatic bit [7:0] seed(bit [7:0] a);
    return 8'(a * 8'd7) ^ 8'h3C;
  endfunction

  // RAM: address sampled each edge, data valid LAT cycles later
  bit [7:0] ram  [256];
  bit       wr_ok[256];
  bit [7:0] ap   [LAT];
  int       nwr;
  always @(posedge arb_clk) begin
    if (ram_we) begin
      ram[ram_addr]   <= ram_wdata;
      wr_ok[ram_addr] <= 1'b1;
      nwr             <= nwr + 1;
    end
    ap[0] <= ram_addr;
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
  end
  assign ram_rdata = wr_ok[ap[LAT-1]] ? ram[ap[LAT-1]] : seed(ap[LAT-1]);

  typedef struct {
    bit       w;
    bit [7:0] a;
    bit [7:0] d;
    int       e0;
    bit       chk;
  } txn_t;

  txn_t     expq[2][$];
  int       n_cmp, n_err;
  bit [7:0] ref_mem[256];
  bit [7:0] exp_rd[2];
  bit       m_last = 1'b1;
  bit       inflight;
  bit       own;
  txn_t     cur;
  int       gnt_cyc;
  logic [1:0] prev_req;
  int       gord[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: grant order, pin values, latency and read data
  always @(negedge arb_clk) begin
    bit p, w;
    int lat;
    if (arb_rst) begin
      m_last   = 1'b1;
      inflight = 1'b0;
      exp_rd   = '{default: 8'h00};
      expq[0].delete();
      expq[1].delete();
    end else begin
      if (|gnt) begin
        p = gnt[1];
        chk("single_gnt", gnt, p ? 2'b10 : 2'b01);
        chk("gnt_while_busy", inflight, 0);
        chk("gnt_req_pending", prev_req[p], 1);
        w = (&prev_req) ? ~m_last : prev_req[1];
        chk("rr_winner", p, w);
        if (expq[p].size() == 0) begin
          fail_now("unexpected_gnt");
        end else begin
          cur      = expq[p][0];
          own      = p;
          inflight = 1'b1;
          gnt_cyc  = cyc;
          m_last   = p;
          gord.push_back(int'(p));
          chk("ram_addr", ram_addr, cur.a);
          if (cur.w) chk("ram_wdata", ram_wdata, cur.d);
          if (cur.chk) chk("gnt_cycle", cyc, cur.e0);
        end
      end
      chk("ram_we", ram_we, (|gnt) && inflight && cur.w);
      for (int q = 0; q < 2; q++) begin
        if (done[q]) begin
          if (!inflight || own != q[0]) begin
            fail_now("spurious_done");
          end else begin
            lat = cur.w ? 1 : 1 + LAT;
            chk("done_latency", cyc - gnt_cyc, lat);
            if (cur.w) ref_mem[cur.a] = cur.d;
            else exp_rd[q] = ref_mem[cur.a];
            void'(expq[q].pop_front());
            inflight = 1'b0;
          end
        end
      end
      chk("cpu_rdata", rdata[0], exp_rd[0]);
      chk("dma_rdata", rdata[1], exp_rd[1]);
    end
    prev_req = req;
  end

  task automatic wait_done(input int p);
    for (int k = 0; k < 40; k++) begin
      @(negedge arb_clk);
      if (done[p]) return;
    end
    fail_now($sformatf("timeout_done_port%0d", p));
  endtask

  task automatic wait_gnt(input int p);
    for (int k = 0; k < 40; k++) begin
      @(negedge arb_clk);
      if (gnt[p]) return;
    end
    fail_now($sformatf("timeout_gnt_port%0d", p));
  endtask

  // Called just after a rising edge; returns just after the drop edge
  task automatic do_txn(input int p, input bit w, input bit [7:0] a,
                        input bit [7:0] d, input bit c);
    txn_t t;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    req[p]   = 1'b1;
    t.w = w; t.a = a; t.d = d; t.e0 = cyc + 1; t.chk = c;
    expq[p].push_back(t);
    wait_done(p);
    @(posedge arb_clk);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int gap;
    for (int i = 0; i < n; i++) begin
      do_txn(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
             8'($urandom), 1'b0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge arb_clk);
        #1;
      end
    end
  endtask

  initial begin
    txn_t t;
    arb_rst = 1'b1;
    req     = '0;
    we      = '0;
    addr    = '{8'h00, 8'h00};
    wdata   = '{8'h00, 8'h00};
    for (int a = 0; a < 256; a++) ref_mem[a] = seed(8'(a));
    repeat (3) @(posedge arb_clk);
    #1;
    arb_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge arb_clk);
      chk("rst_ctrl", {gnt, done, ram_we, busy}, 0);
      chk("rst_ram_pins", {ram_addr, ram_wdata}, 0);
    end
    chk("rst_ram_untouched", nwr, 0);
    @(posedge arb_clk);
    #1;

    gord.delete();
    fork
      begin
        do_txn(0, 1'b0, 8'h10, 8'h00, 1'b0);
        do_txn(0, 1'b0, 8'h10, 8'h00, 1'b0);
      end
      begin
        do_txn(1, 1'b1, 8'h20, 8'h5A, 1'b0);
        do_txn(1, 1'b1, 8'h20, 8'h5B, 1'b0);
      end
    join
    chk("tie_count", gord.size(), 4);
    for (int i = 0; i < gord.size(); i++) chk("tie_order", gord[i], i % 2);

    do_txn(0, 1'b1, 8'h3C, 8'hA5, 1'b1);
    do_txn(0, 1'b0, 8'h3C, 8'h00, 1'b1);
    chk("cpu_read_3c", rdata[0], 8'hA5);
    chk("dma_rdata_kept", rdata[1], 8'h00);

    do_txn(1, 1'b1, 8'hFF, 8'h77, 1'b1);
    do_txn(1, 1'b0, 8'hFF, 8'h00, 1'b1);
    chk("dma_read_ff", rdata[1], 8'h77);

    we[0] = 1'b0; addr[0] = 8'h3C; req[0] = 1'b1;
    t.w = 1'b0; t.a = 8'h3C; t.d = 8'h00; t.e0 = cyc + 1; t.chk = 1'b1;
    expq[0].push_back(t);
    wait_gnt(0);
    @(posedge arb_clk);
    #3;
    arb_rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_state", u_dut.state, 0);
    chk("rst_mid_outs", {gnt, done, ram_we}, 0);
    req[0] = 1'b0;
    repeat (2) @(posedge arb_clk);
    #1;
    arb_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge arb_clk);
      chk("rst_no_done", done, 0);
    end
    @(posedge arb_clk);
    #1;
    do_txn(0, 1'b0, 8'h3C, 8'h00, 1'b1);
    chk("reissue_read", rdata[0], 8'hA5);

    we[0] = 1'b0; addr[0] = 8'h20; req[0] = 1'b1;
    t.w = 1'b0; t.a = 8'h20; t.d = 8'h00; t.e0 = cyc + 1; t.chk = 1'b1;
    expq[0].push_back(t);
    wait_gnt(0);
    @(posedge arb_clk);
    #1;
    req[0] = 1'b0;
    wait_done(0);
    chk("drop_read_data", rdata[0], 8'h5B);
    for (int i = 0; i < 6; i++) begin
      @(negedge arb_clk);
      chk("drop_no_second", gnt, 0);
    end
    @(posedge arb_clk);
    #1;

    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join

    repeat (5) @(negedge arb_clk);
    chk("cpu_queue_empty", expq[0].size(), 0);
    chk("dma_queue_empty", expq[1].size(), 0);
    chk("idle_at_end", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
